// File: rtl/simon_seq.sv
// simon_seq: parametrised Simon-game sequencer.
// Stores the random sequence in a small memory and replays it every round.
// It then checks the player's replay entry by entry. All timing is
// qualified by the tick strobe.
// Optional feature macro: SIMON_SPEEDUP_EN. When it is defined, rounds above
// MAX_LEVEL/2 play back with halved lamp on/off durations.
module simon_seq #(
  parameter int          BTN_W         = 2,
  parameter int          MAX_LEVEL     = 16,
  parameter int          ON_TICKS      = 30,
  parameter int          OFF_TICKS     = 30,
  parameter int          TIMEOUT_TICKS = 120,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tick,
  input  logic                             start,
  input  logic [BTN_W-1:0]                 player_num,
  input  logic                             player_pressed,
  output logic                             simon_turn,
  output logic [BTN_W-1:0]                 simon_num,
  output logic                             simon_pressed,
  output logic [$clog2(MAX_LEVEL+1)-1:0]   level,
  output logic                             game_over,
  output logic                             win
);

  localparam int LVL_W    = $clog2(MAX_LEVEL + 1);
  localparam int IDX_W    = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam int CNT_MAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_MAX  = (TIMEOUT_TICKS > CNT_MAX0) ? TIMEOUT_TICKS : CNT_MAX0;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [LVL_W-1:0] MAX_LVL   = LVL_W'(MAX_LEVEL);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADD, ST_SHOW_ON, ST_SHOW_OFF, ST_WAIT_IN, ST_LOSE, ST_WIN
  } state_t;

  // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               simon_turn_q, simon_turn_d;
  logic [BTN_W-1:0]   simon_num_q, simon_num_d;
  logic               simon_pressed_q, simon_pressed_d;
  logic               game_over_q, game_over_d;
  logic               win_q, win_d;

  logic [BTN_W-1:0]   mem_q [MAX_LEVEL];
  logic               mem_we_s;
  logic [IDX_W-1:0]   mem_addr_s;
  logic [BTN_W-1:0]   mem_wdata_s;
  logic [BTN_W-1:0]   cur_num_s;
  logic [BTN_W-1:0]   show_num_s;
  logic               last_s;
  logic [CNT_W-1:0]   on_last_s;
  logic [CNT_W-1:0]   off_last_s;

`ifdef SIMON_SPEEDUP_EN
  localparam int ON_FAST  = ((ON_TICKS >> 1) >= 1) ? (ON_TICKS >> 1) : 1;
  localparam int OFF_FAST = ((OFF_TICKS >> 1) >= 1) ? (OFF_TICKS >> 1) : 1;
  localparam logic [CNT_W-1:0] ON_FAST_LAST  = CNT_W'(ON_FAST - 1);
  localparam logic [CNT_W-1:0] OFF_FAST_LAST = CNT_W'(OFF_FAST - 1);
  localparam logic [LVL_W-1:0] HALF_LVL      = LVL_W'(MAX_LEVEL / 2);

  // Late rounds play back at double speed; level is constant during playback
  always_comb begin
    if (level_q > HALF_LVL) begin
      on_last_s  = ON_FAST_LAST;
      off_last_s = OFF_FAST_LAST;
    end else begin
      on_last_s  = ON_LAST;
      off_last_s = OFF_LAST;
    end
  end
`else
  // Playback durations are fixed
  always_comb begin
    on_last_s  = ON_LAST;
    off_last_s = OFF_LAST;
  end
`endif

  assign cur_num_s = mem_q[idx_q];
  assign last_s    = (LVL_W'(idx_q) == (level_q - LVL_W'(1)));
  assign lfsr_d    = lfsr_step(lfsr_q);

  // Next-state logic for the game FSM, counters and sequence memory write
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    mem_we_s    = 1'b0;
    mem_addr_s  = level_q[IDX_W-1:0];
    mem_wdata_s = lfsr_q[BTN_W-1:0];
    case (state_q)
      ST_IDLE, ST_LOSE, ST_WIN: begin
        if (start) begin
          level_d = LVL_W'(0);
          state_d = ST_ADD;
        end else begin
          state_d = state_q;
        end
      end
      ST_ADD: begin
        mem_we_s = 1'b1;
        level_d  = level_q + LVL_W'(1);
        idx_d    = IDX_W'(0);
        cnt_d    = CNT_W'(0);
        state_d  = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (tick) begin
          if (cnt_q == on_last_s) begin
            cnt_d   = CNT_W'(0);
            state_d = ST_SHOW_OFF;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_SHOW_OFF: begin
        if (tick) begin
          if (cnt_q == off_last_s) begin
            cnt_d = CNT_W'(0);
            if (last_s) begin
              idx_d   = IDX_W'(0);
              state_d = ST_WAIT_IN;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = ST_SHOW_ON;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_WAIT_IN: begin
        // A press takes priority over a timeout in the same cycle
        if (player_pressed) begin
          if (player_num == cur_num_s) begin
            cnt_d = CNT_W'(0);
            if (last_s) begin
              state_d = (level_q == MAX_LVL) ? ST_WIN : ST_ADD;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            state_d = ST_LOSE;
          end
        end else if (tick) begin
          if (cnt_q == TO_LAST) begin
            state_d = ST_LOSE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the output flops track the state flop
  always_comb begin
    show_num_s = mem_q[idx_d];
    if (mem_we_s && (mem_addr_s == idx_d)) begin
      show_num_s = mem_wdata_s;
    end else begin
      show_num_s = mem_q[idx_d];
    end
    simon_turn_d    = 1'b0;
    simon_num_d     = BTN_W'(0);
    simon_pressed_d = 1'b0;
    game_over_d     = 1'b0;
    win_d           = 1'b0;
    case (state_d)
      ST_ADD: begin
        simon_turn_d = 1'b1;
      end
      ST_SHOW_ON: begin
        simon_turn_d    = 1'b1;
        simon_pressed_d = 1'b1;
        simon_num_d     = show_num_s;
      end
      ST_SHOW_OFF: begin
        simon_turn_d = 1'b1;
        simon_num_d  = show_num_s;
      end
      ST_LOSE: begin
        game_over_d = 1'b1;
      end
      ST_WIN: begin
        game_over_d = 1'b1;
        win_d       = 1'b1;
      end
      default: begin
        simon_turn_d = 1'b0;
      end
    endcase
  end

  // State, counters, LFSR and registered outputs; reset aborts any game
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      idx_q           <= IDX_W'(0);
      cnt_q           <= CNT_W'(0);
      level_q         <= LVL_W'(0);
      lfsr_q          <= SEED;
      simon_turn_q    <= 1'b0;
      simon_num_q     <= BTN_W'(0);
      simon_pressed_q <= 1'b0;
      game_over_q     <= 1'b0;
      win_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      level_q         <= level_d;
      lfsr_q          <= lfsr_d;
      simon_turn_q    <= simon_turn_d;
      simon_num_q     <= simon_num_d;
      simon_pressed_q <= simon_pressed_d;
      game_over_q     <= game_over_d;
      win_q           <= win_d;
    end
  end

  // Sequence memory: single write port, contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_addr_s] <= mem_wdata_s;
    end
  end

  assign simon_turn    = simon_turn_q;
  assign simon_num     = simon_num_q;
  assign simon_pressed = simon_pressed_q;
  assign level         = level_q;
  assign game_over     = game_over_q;
  assign win           = win_q;

endmodule

// File: tb/tb_simon_seq.sv
// tb_simon_seq: scoreboard bench for simon_seq (BTN_W=2, MAX_LEVEL=4,
// ON=2, OFF=2, TIMEOUT=5). Stimulus pushes expected lamps and game endings
// into queues; a monitor pops and compares them as the DUT shows them.
module tb_simon_seq;

  localparam int BTN_W     = 2;
  localparam int MAX_LEVEL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       start;
  logic [1:0] player_num;
  logic       player_pressed;
  logic       simon_turn;
  logic [1:0] simon_num;
  logic       simon_pressed;
  logic [2:0] level;
  logic       game_over;
  logic       win;

  simon_seq #(
    .BTN_W(BTN_W), .MAX_LEVEL(MAX_LEVEL), .ON_TICKS(2), .OFF_TICKS(2),
    .TIMEOUT_TICKS(5), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .player_num(player_num), .player_pressed(player_pressed),
    .simon_turn(simon_turn), .simon_num(simon_num), .simon_pressed(simon_pressed),
    .level(level), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] num; logic [7:0] on_len; logic [7:0] off_len; } lamp_t;
  typedef struct packed { logic w; logic [2:0] lvl; } end_t;

  lamp_t      lamp_q[$];
  end_t       end_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [15:0] m_lfsr;
  logic [1:0] exp_seq [4];
  int         exp_level = 0;
  logic       mon_en = 1'b0;

  logic       mon_act = 1'b0;
  logic       mon_off = 1'b0;
  logic [1:0] mon_num = 2'd0;
  int         mon_on_len = 0;
  int         mon_off_len = 0;
  logic       mon_stable = 1'b1;
  logic       go_prev = 1'b0;

  // Reference random source: 16-bit Fibonacci LFSR, taps 16,14,13,11
  always @(posedge clk) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic int exp_on(input int lvl);
`ifdef SIMON_SPEEDUP_EN
    if (lvl > MAX_LEVEL / 2) return 1;
`endif
    return 2;
  endfunction

  function automatic int exp_off(input int lvl);
`ifdef SIMON_SPEEDUP_EN
    if (lvl > MAX_LEVEL / 2) return 1;
`endif
    return 2;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  task automatic finalize_lamp();
    lamp_t e;
    if (lamp_q.size() == 0) begin
      n_checks++;
      $display("FAIL lamp_extra: got lamp %0d, expected no lamp", mon_num);
    end else begin
      e = lamp_q.pop_front();
      check("lamp_num", int'(mon_num), int'(e.num));
      check("lamp_on_len", mon_on_len, int'(e.on_len));
      check("lamp_off_len", mon_off_len, int'(e.off_len));
      check("lamp_num_stable", int'(mon_stable), 1);
    end
  endtask

  // Monitor: measures each lamp and each game ending, compares with queues
  initial begin
    end_t ee;
    forever begin
      @(negedge clk);
      if (!mon_en || !reset) begin
        mon_act = 1'b0;
      end else if (simon_pressed) begin
        if (mon_act && mon_off) finalize_lamp();
        if (!mon_act || mon_off) begin
          mon_act = 1'b1; mon_off = 1'b0; mon_num = simon_num;
          mon_on_len = 1; mon_off_len = 0; mon_stable = 1'b1;
        end else begin
          mon_on_len++;
          if (simon_num != mon_num) mon_stable = 1'b0;
        end
      end else if (simon_turn && mon_act) begin
        mon_off = 1'b1;
        mon_off_len++;
        if (simon_num != mon_num) mon_stable = 1'b0;
      end else if (!simon_turn && mon_act) begin
        finalize_lamp();
        mon_act = 1'b0;
      end
      if (mon_en && reset && game_over && !go_prev) begin
        if (end_q.size() == 0) begin
          n_checks++;
          $display("FAIL game_end_extra: got game_over win=%0d, expected no ending", win);
        end else begin
          ee = end_q.pop_front();
          check("end_win", int'(win), int'(ee.w));
          check("end_level", int'(level), int'(ee.lvl));
        end
      end
      go_prev = game_over;
    end
  end

  task automatic do_start();
    exp_level = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in the ADD cycle: record the new entry and queue the playback
  task automatic new_round(input int extra_on);
    lamp_t e;
    exp_seq[exp_level] = m_lfsr[1:0];
    exp_level++;
    for (int k = 0; k < exp_level; k++) begin
      e.num     = exp_seq[k];
      e.on_len  = 8'(exp_on(exp_level) + ((k == 0) ? extra_on : 0));
      e.off_len = 8'(exp_off(exp_level));
      lamp_q.push_back(e);
    end
  endtask

  task automatic wait_player();
    logic seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = !simon_turn;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL wait_player: got simon_turn=1 for 200 cycles, expected 0");
    end
  endtask

  task automatic wait_lamp();
    logic seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = simon_pressed;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL wait_lamp: got simon_pressed=0 for 50 cycles, expected 1");
    end
  endtask

  task automatic press(input logic [1:0] num);
    player_num = num;
    player_pressed = 1'b1;
    @(negedge clk);
    player_pressed = 1'b0;
  endtask

  task automatic play_all();
    for (int k = 0; k < exp_level; k++) press(exp_seq[k]);
  endtask

  function automatic int outs();
    return int'({simon_turn, simon_num, simon_pressed, level, game_over, win});
  endfunction

  initial begin
    reset = 1'b0; tick = 1'b1; start = 1'b0;
    player_pressed = 1'b0; player_num = 2'd0;
    @(negedge clk);
    check("rst_simon_turn", int'(simon_turn), 0);
    check("rst_simon_num", int'(simon_num), 0);
    check("rst_simon_pressed", int'(simon_pressed), 0);
    check("rst_level", int'(level), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_win", int'(win), 0);
    reset = 1'b1;
    mon_en = 1'b1;

    // IDLE ignores everything but start
    player_pressed = 1'b1; player_num = 2'd3;
    for (int i = 0; i < 4; i++) begin
      tick = i[0];
      @(negedge clk);
    end
    player_pressed = 1'b0; tick = 1'b1;
    check("idle_hold", outs(), 0);

    // Game 1: four correct rounds, tick stalled during the first lamp
    do_start();
    check("add_simon_turn", int'(simon_turn), 1);
    check("add_simon_pressed", int'(simon_pressed), 0);
    new_round(3);
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    wait_player();
    check("g1_level1", int'(level), 1);
    play_all();
    new_round(0);
    wait_player();
    check("g1_level2", int'(level), 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    play_all();
    new_round(0);
    wait_player();
    check("g1_level3", int'(level), 3);
    play_all();
    new_round(0);
    wait_player();
    check("g1_level4", int'(level), 4);
    end_q.push_back('{w: 1'b1, lvl: 3'd4});
    play_all();
    check("win_game_over", int'(game_over), 1);
    check("win_win", int'(win), 1);
    check("win_level", int'(level), 4);

    // Game 2: wrong press in round 2
    do_start();
    new_round(0);
    wait_player();
    check("g2_level1", int'(level), 1);
    play_all();
    new_round(0);
    wait_player();
    end_q.push_back('{w: 1'b0, lvl: 3'd2});
    press(exp_seq[0] ^ 2'd1);
    check("lose_game_over", int'(game_over), 1);
    check("lose_win", int'(win), 0);
    check("lose_level", int'(level), 2);

    // Game 3: press on the timeout tick, then a real timeout
    do_start();
    new_round(0);
    wait_player();
    check("restart_level", int'(level), 1);
    repeat (4) @(negedge clk);
    check("pre_timeout_go", int'(game_over), 0);
    press(exp_seq[0]);
    check("press_beats_timeout_go", int'(game_over), 0);
    check("press_beats_timeout_turn", int'(simon_turn), 1);
    new_round(0);
    wait_player();
    repeat (4) @(negedge clk);
    check("timeout_4th_go", int'(game_over), 0);
    end_q.push_back('{w: 1'b0, lvl: 3'd2});
    @(negedge clk);
    check("timeout_5th_go", int'(game_over), 1);

    // Game 4: press during playback ignored, then reset mid-SHOW_ON
    do_start();
    new_round(0);
    wait_lamp();
    press(exp_seq[0] ^ 2'd1);
    wait_player();
    check("show_press_ignored_go", int'(game_over), 0);
    check("show_press_ignored_level", int'(level), 1);
    play_all();
    new_round(0);
    wait_lamp();
    mon_en = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midshow_reset_outs", outs(), 0);
    lamp_q.delete();
    end_q.delete();
    mon_en = 1'b1;
    do_start();
    new_round(0);
    wait_player();
    check("post_reset_level", int'(level), 1);
    @(negedge clk);
    check("lamp_queue_empty", lamp_q.size(), 0);
    check("end_queue_empty", end_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog against a hung run
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/simon_seq.md
Name: simon_seq

Overview:
- Parametrised Simon-game sequencer, successor to the fixed 4-button game core.
- Stores the full random sequence in an internal memory and replays the whole sequence each round, then checks the player's replay entry by entry.
- Button count, maximum level and timing are generics. A `tick` strobe qualifies all timing, so the block runs from any system clock.
- Sits between the button/debounce logic and the lamp/display driver.

Parameters:
- BTN_W, 2: width of a button index; 2**BTN_W buttons.
- MAX_LEVEL, 16: maximum sequence length; completing it wins.
- ON_TICKS, 30: ticks a lamp is lit during playback (>=1).
- OFF_TICKS, 30: ticks of dark gap after each lamp (>=1).
- TIMEOUT_TICKS, 120: ticks allowed between player presses (>=1).
- SEED, 16'hACE1: nonzero reset value of the internal 16-bit LFSR.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- tick  in  1  timing strobe; counters advance only when high.
- start  in  1  one-cycle pulse; starts a new game from IDLE, LOSE or WIN.
- player_num  in  BTN_W  button index of the player press.
- player_pressed  in  1  one-cycle pulse; player_num is valid in that cycle.
- simon_turn  out  1  1 while Simon plays back; 0 while awaiting the player.
- simon_num  out  BTN_W  lamp index shown during playback.
- simon_pressed  out  1  lamp lit (SHOW_ON).
- level  out  clog2(MAX_LEVEL+1)  current sequence length.
- game_over  out  1  game ended (LOSE or WIN).
- win  out  1  game ended by completing MAX_LEVEL.

Behaviour:
- Reset is sampled at the clk edge with reset==0.
  - Next state is IDLE; idx, cnt and level are cleared; LFSR is loaded with SEED.
  - All outputs read 0.
  - Sequence memory is not cleared.
  - Reset in any state, including mid-playback, aborts immediately.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Steps every clk cycle outside reset.
  - The random value is lfsr[BTN_W-1:0].
- States: IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, LOSE, WIN. All outputs are decoded from registered state and registers.
- IDLE:
  - Outputs 0.
  - start=1: level<=0, then go to ADD.
- ADD (1 cycle):
  - mem[level]<=random; level<=level+1; idx<=0; cnt<=0; go to SHOW_ON.
  - simon_turn=1.
- SHOW_ON:
  - simon_turn=1, simon_pressed=1, simon_num=mem[idx].
  - On a tick with cnt==ON_TICKS-1: cnt<=0, go to SHOW_OFF.
  - Otherwise, on a tick, cnt++.
- SHOW_OFF:
  - simon_turn=1, simon_pressed=0, simon_num holds mem[idx].
  - On a tick with cnt==OFF_TICKS-1: cnt<=0.
    - If idx==level-1: idx<=0, go to WAIT_IN.
    - Else: idx++, go to SHOW_ON.
- WAIT_IN:
  - simon_turn=0, simon_pressed=0.
  - player_pressed with player_num==mem[idx]: cnt<=0.
    - If idx==level-1: go to WIN if level==MAX_LEVEL, else go to ADD.
    - Else: idx++.
  - player_pressed with a mismatch: go to LOSE.
  - No press and tick with cnt==TIMEOUT_TICKS-1: go to LOSE.
  - No press and tick otherwise: cnt++.
  - A press and a timeout in the same cycle: the press wins (timeout ignored).
- LOSE: game_over=1, win=0. WIN: game_over=1, win=1.
  - In both, level holds its final value.
  - start=1 behaves as in IDLE (new game).
- Ignored inputs:
  - player_pressed outside WAIT_IN.
  - start outside IDLE, LOSE and WIN.
  - player_num is don't-care when player_pressed=0.
- Latency:
  - Each transition takes effect on the clk edge where its condition holds.
  - game_over rises 1 cycle after a failing press.
- Memory is MAX_LEVEL x BTN_W with asynchronous read and one write port (ADD only).

Optional Feature:
SIMON_SPEEDUP_EN:
- Defined: when level > MAX_LEVEL/2, the SHOW_ON and SHOW_OFF durations become max(1, ON_TICKS>>1) and max(1, OFF_TICKS>>1). This is evaluated at SHOW entry. TIMEOUT is unchanged.
- Undefined: playback timing is always ON_TICKS/OFF_TICKS.

Test Plan (BTN_W=2, MAX_LEVEL=4, ON=2, OFF=2, TIMEOUT=5, tick tied 1, SEED default):
- Reset low 1 cycle -> all outputs 0, level=0. Inputs during IDLE except start -> no change.
- start pulse -> ADD 1 cycle, then simon_pressed=1 for 2 cycles and 0 for 2 cycles; simon_num stable; then simon_turn=0, level=1.
- Replay each shown index correctly for 4 rounds -> round n shows n lamps in order and earlier entries are unchanged. After the 4th correct press, next cycle: win=1, game_over=1, level=4.
- Round 2, press with player_num=mem[0]^1 -> next cycle game_over=1, win=0, level=2. A further start -> level=1, new game.
- In WAIT_IN, no press for 5 ticks -> game_over=1 on the 5th tick edge. A correct press on the tick that would time out -> game continues.
- Reset low mid-SHOW_ON -> next cycle all outputs 0. player_pressed during SHOW -> ignored, the sequence continues unchanged.
- With SIMON_SPEEDUP_EN and level=3 -> lamp on 1 cycle, off 1 cycle.
